// File: rtl/counter_axil_regs.sv
// AXI4-Lite register block around the free-running LED counter: speed select,
// clear pulse, live count readback, wrap counter and a scratch word.
module counter_axil_regs #(
  parameter int         BIT_WIDTH   = 32,
  parameter int         ADDR_WIDTH  = 4,
  parameter logic [3:0] RESET_SPEED = 4'h1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [BIT_WIDTH-1:0]  counter_in,
  output logic [3:0]            sw_out,
  output logic                  cnt_clear
);

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_WRAPS   = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  logic                 aw_held_r, w_held_r, awready_r, wready_r, bvalid_r;
  logic                 arready_r, rvalid_r, clear_r;
  logic [1:0]           aw_sel_r;
  logic [31:0]          w_data_r, rdata_r, wraps_r, scratch_r;
  logic [3:0]           w_strb_r, speed_r;
  logic [BIT_WIDTH-1:0] cnt_prev_r;

  logic        aw_hs_s, w_hs_s, ar_hs_s, commit_s, clear_s, wrap_s;
  logic        aw_held_nx_s, w_held_nx_s, bvalid_nx_s, rvalid_nx_s;
  logic [1:0]  wr_sel_s;
  logic [31:0] wr_data_s, rd_mux_s, cnt_ext_s;
  logic [3:0]  wr_strb_s;
  logic        unused_addr_s;

  // Write channel: a held beat or a live handshake on each side forms the commit.
  always_comb begin
    aw_hs_s      = s_axi_awvalid & awready_r;
    w_hs_s       = s_axi_wvalid & wready_r;
    commit_s     = (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);
    wr_sel_s     = aw_held_r ? aw_sel_r : s_axi_awaddr[3:2];
    wr_data_s    = w_held_r ? w_data_r : s_axi_wdata;
    wr_strb_s    = w_held_r ? w_strb_r : s_axi_wstrb;
    aw_held_nx_s = ~commit_s & (aw_held_r | aw_hs_s);
    w_held_nx_s  = ~commit_s & (w_held_r | w_hs_s);
    clear_s      = commit_s & (wr_sel_s == REG_CTRL) & wr_strb_s[0] & wr_data_s[4];
    if (commit_s) begin
      bvalid_nx_s = 1'b1;
    end else if (s_axi_bready) begin
      bvalid_nx_s = 1'b0;
    end else begin
      bvalid_nx_s = bvalid_r;
    end
  end

  // Read channel, read mux and wrap detect.
  always_comb begin
    ar_hs_s   = s_axi_arvalid & arready_r;
    cnt_ext_s = 32'(counter_in);
    wrap_s    = (cnt_prev_r == {BIT_WIDTH{1'b1}}) & (counter_in == {BIT_WIDTH{1'b0}});
    if (ar_hs_s) begin
      rvalid_nx_s = 1'b1;
    end else if (s_axi_rready) begin
      rvalid_nx_s = 1'b0;
    end else begin
      rvalid_nx_s = rvalid_r;
    end
    case (s_axi_araddr[3:2])
      REG_CTRL:    rd_mux_s = {28'h0000000, speed_r};
      REG_COUNT:   rd_mux_s = cnt_ext_s;
      REG_WRAPS:   rd_mux_s = wraps_r;
      REG_SCRATCH: rd_mux_s = scratch_r;
      default:     rd_mux_s = 32'h00000000;
    endcase
  end

  // Handshake state; ready flags are registered from next-cycle holding/valid state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_r <= 1'b0;
      aw_sel_r  <= 2'd0;
      w_held_r  <= 1'b0;
      w_data_r  <= 32'h00000000;
      w_strb_r  <= 4'h0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'h00000000;
    end else begin
      aw_held_r <= aw_held_nx_s;
      w_held_r  <= w_held_nx_s;
      if (aw_hs_s) begin
        aw_sel_r <= s_axi_awaddr[3:2];
      end
      if (w_hs_s) begin
        w_data_r <= s_axi_wdata;
        w_strb_r <= s_axi_wstrb;
      end
      awready_r <= ~aw_held_nx_s & ~bvalid_nx_s;
      wready_r  <= ~w_held_nx_s & ~bvalid_nx_s;
      bvalid_r  <= bvalid_nx_s;
      arready_r <= ~rvalid_nx_s;
      rvalid_r  <= rvalid_nx_s;
      if (ar_hs_s) begin
        rdata_r <= rd_mux_s;
      end
    end
  end

  // Software-visible registers; clear wins over a coincident wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_r    <= RESET_SPEED;
      clear_r    <= 1'b0;
      scratch_r  <= 32'h00000000;
      wraps_r    <= 32'h00000000;
      cnt_prev_r <= {BIT_WIDTH{1'b0}};
    end else begin
      clear_r <= clear_s;
      if (commit_s && (wr_sel_s == REG_CTRL) && wr_strb_s[0]) begin
        speed_r <= wr_data_s[3:0];
      end
      if (commit_s && (wr_sel_s == REG_SCRATCH)) begin
        for (int i = 0; i < 4; i++) begin
          if (wr_strb_s[i]) begin
            scratch_r[8*i +: 8] <= wr_data_s[8*i +: 8];
          end
        end
      end
      if (clear_s) begin
        wraps_r    <= 32'h00000000;
        cnt_prev_r <= {BIT_WIDTH{1'b0}};
      end else begin
        cnt_prev_r <= counter_in;
        if (wrap_s && (wraps_r != 32'hFFFFFFFF)) begin
          wraps_r <= wraps_r + 32'd1;
        end
      end
    end
  end

  assign unused_addr_s = ^{s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = 2'b00;
  assign sw_out        = speed_r;
  assign cnt_clear     = clear_r;

endmodule

// File: tb/tb_counter_axil_regs.sv
// Self-checking bench for counter_axil_regs: directed vectors, corner-case
// sequences and randomized traffic against a register-level model.
module tb_counter_axil_regs;

  logic        clk, rst_n;
  logic [3:0]  s_axi_awaddr, s_axi_araddr;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] counter_in;
  logic [3:0]  sw_out;
  logic        cnt_clear;

  int checks = 0;
  int failures = 0;

  // model state
  logic [3:0]  m_speed;
  logic [31:0] m_scratch, m_wraps, m_last;

  counter_axil_regs dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .counter_in(counter_in), .sw_out(sw_out), .cnt_clear(cnt_clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int clr = 0;
    case (a[3:2])
      2'd0: begin
        if (s[0]) begin
          m_speed = d[3:0];
          if (d[4]) begin
            clr = 1;
            m_wraps = 32'h0;
          end
        end
      end
      2'd3: begin
        for (int i = 0; i < 4; i++) if (s[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
      end
      default: ;
    endcase
    return clr;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {28'h0, m_speed};
      2'd1:    return m_last;
      2'd2:    return m_wraps;
      default: return m_scratch;
    endcase
  endfunction

  task automatic step(input logic [31:0] v);
    counter_in = v;
    tick();
    if (m_last == 32'hFFFFFFFF && v == 32'h0 && m_wraps != 32'hFFFFFFFF) m_wraps++;
    m_last = v;
  endtask

  // Called at a negedge; leaves at a negedge with the response consumed.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int stall, output int pulses);
    bit aw_done, w_done, awf, wf;
    int n;
    aw_done = 0; w_done = 0; n = 0; pulses = 0;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      awf = s_axi_awvalid && s_axi_awready;
      wf  = s_axi_wvalid && s_axi_wready;
      tick();
      n++;
      pulses += int'(cnt_clear);
      if (awf) begin aw_done = 1; s_axi_awvalid = 1'b0; end
      if (wf) begin w_done = 1; s_axi_wvalid = 1'b0; end
    end
    check("wr_accept", {31'h0, aw_done && w_done}, 32'h1);
    check("bvalid_latency", {31'h0, s_axi_bvalid}, 32'h1);
    check("bresp", {30'h0, s_axi_bresp}, 32'h0);
    for (int i = 0; i < stall; i++) begin
      check("bvalid_hold", {31'h0, s_axi_bvalid}, 32'h1);
      check("awready_blocked", {31'h0, s_axi_awready}, 32'h0);
      check("wready_blocked", {31'h0, s_axi_wready}, 32'h0);
      tick();
      pulses += int'(cnt_clear);
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    pulses += int'(cnt_clear);
    check("bvalid_drop", {31'h0, s_axi_bvalid}, 32'h0);
  endtask

  task automatic axi_read(input logic [3:0] a, input int stall, output logic [31:0] d);
    bit arf;
    int n;
    arf = 0; n = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    while (!arf && n < 20) begin
      arf = s_axi_arready;
      tick();
      n++;
    end
    s_axi_arvalid = 1'b0;
    check("rd_accept", {31'h0, arf}, 32'h1);
    check("rvalid_latency", {31'h0, s_axi_rvalid}, 32'h1);
    check("rresp", {30'h0, s_axi_rresp}, 32'h0);
    d = s_axi_rdata;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("rvalid_hold", {31'h0, s_axi_rvalid}, 32'h1);
      check("rdata_stable", s_axi_rdata, d);
      check("arready_blocked", {31'h0, s_axi_arready}, 32'h0);
    end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check("rvalid_drop", {31'h0, s_axi_rvalid}, 32'h0);
  endtask

  typedef struct {
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [31:0] cnt;
    logic [3:0]  ra;
    logic [31:0] exp_rd;
    logic [3:0]  exp_sw;
    int          exp_clr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] rd;
    int          pulses, exp_clr, op;
    logic [3:0]  a, s;
    logic [31:0] d, v;

    vecs[0] = '{4'hC, 32'hA5A5A5A5, 4'b0101, 32'h0,      4'hC, 32'h00A500A5, 4'h0, 0};
    vecs[1] = '{4'hC, 32'h12345678, 4'b1010, 32'h0,      4'hC, 32'h12A556A5, 4'h0, 0};
    vecs[2] = '{4'h0, 32'hFFFFFFE7, 4'b0001, 32'h0,      4'h0, 32'h00000007, 4'h7, 0};
    vecs[3] = '{4'h0, 32'h0000001B, 4'b1110, 32'h0,      4'h0, 32'h00000007, 4'h7, 0};
    vecs[4] = '{4'h4, 32'hDEADBEEF, 4'b1111, 32'h00C0FFEE, 4'h4, 32'h00C0FFEE, 4'h7, 0};
    vecs[5] = '{4'h8, 32'hFFFFFFFF, 4'b1111, 32'h0,      4'h8, 32'h00000000, 4'h7, 0};
    vecs[6] = '{4'hF, 32'hCAFEF00D, 4'b1111, 32'h0,      4'hC, 32'hCAFEF00D, 4'h7, 0};
    vecs[7] = '{4'h0, 32'h00000039, 4'b0001, 32'h0,      4'h0, 32'h00000009, 4'h9, 1};
    vecs[8] = '{4'h3, 32'h0000000C, 4'b0001, 32'h0,      4'h1, 32'h0000000C, 4'hC, 0};

    rst_n = 1'b0;
    s_axi_awaddr = 4'h0; s_axi_awvalid = 1'b0; s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = 4'h0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; counter_in = 32'h0;
    m_speed = 4'h1; m_scratch = 32'h0; m_wraps = 32'h0; m_last = 32'h0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_awready", {31'h0, s_axi_awready}, 32'h0);
    check("rst_wready", {31'h0, s_axi_wready}, 32'h0);
    check("rst_arready", {31'h0, s_axi_arready}, 32'h0);
    check("rst_bvalid", {31'h0, s_axi_bvalid}, 32'h0);
    check("rst_rvalid", {31'h0, s_axi_rvalid}, 32'h0);
    check("rst_rdata", s_axi_rdata, 32'h0);
    check("rst_sw_out", {28'h0, sw_out}, 32'h1);
    check("rst_cnt_clear", {31'h0, cnt_clear}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_awready", {31'h0, s_axi_awready}, 32'h1);
    check("post_rst_wready", {31'h0, s_axi_wready}, 32'h1);
    check("post_rst_arready", {31'h0, s_axi_arready}, 32'h1);
    foreach (vecs[i]) begin
      if (i < 3) begin
        a = (i == 0) ? 4'h0 : ((i == 1) ? 4'h8 : 4'hC);
        axi_read(a, 0, rd);
        check("rst_read", rd, model_read(a));
        check("rst_sw_hold", {28'h0, sw_out}, 32'h1);
        check("rst_clear_low", {31'h0, cnt_clear}, 32'h0);
      end
    end

    // W three cycles ahead of AW
    s_axi_wdata = 32'h14; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    check("w_first_ready", {31'h0, s_axi_wready}, 32'h1);
    tick();
    s_axi_wvalid = 1'b0;
    repeat (3) begin
      check("w_held_wready", {31'h0, s_axi_wready}, 32'h0);
      check("w_held_nobvalid", {31'h0, s_axi_bvalid}, 32'h0);
      check("w_held_noclear", {31'h0, cnt_clear}, 32'h0);
      tick();
    end
    s_axi_awaddr = 4'h0; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    check("wfirst_bvalid", {31'h0, s_axi_bvalid}, 32'h1);
    check("wfirst_clear", {31'h0, cnt_clear}, 32'h1);
    check("wfirst_sw_out", {28'h0, sw_out}, 32'h4);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("wfirst_clear_once", {31'h0, cnt_clear}, 32'h0);
    check("wfirst_bvalid_drop", {31'h0, s_axi_bvalid}, 32'h0);
    void'(model_write(4'h0, 32'h14, 4'hF));
    axi_read(4'h0, 0, rd);
    check("wfirst_ctrl_read", rd, 32'h4);

    // wrap detection, then clear coincident with a second wrap
    step(32'hFFFFFFFE); step(32'hFFFFFFFF); step(32'h0); step(32'h1);
    axi_read(4'h8, 0, rd);
    check("wraps_one", rd, 32'h1);
    axi_read(4'h4, 0, rd);
    check("count_read", rd, 32'h1);
    step(32'hFFFFFFFF);
    counter_in = 32'h0;
    s_axi_awaddr = 4'h0; s_axi_wdata = 32'h10; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("clrwrap_bvalid", {31'h0, s_axi_bvalid}, 32'h1);
    check("clrwrap_pulse", {31'h0, cnt_clear}, 32'h1);
    check("clrwrap_sw_out", {28'h0, sw_out}, 32'h0);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    m_speed = 4'h0; m_wraps = 32'h0; m_last = 32'h0;
    axi_read(4'h8, 0, rd);
    check("clrwrap_wraps", rd, 32'h0);

    // directed vectors
    foreach (vecs[i]) begin
      step(vecs[i].cnt);
      axi_write(vecs[i].wa, vecs[i].wd, vecs[i].ws, 0, pulses);
      void'(model_write(vecs[i].wa, vecs[i].wd, vecs[i].ws));
      check($sformatf("vec%0d_clear", i), pulses, vecs[i].exp_clr);
      check($sformatf("vec%0d_sw", i), {28'h0, sw_out}, {28'h0, vecs[i].exp_sw});
      axi_read(vecs[i].ra, 0, rd);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // ready held low for five cycles on each response channel
    axi_read(4'hC, 5, rd);
    check("stall_rdata", rd, m_scratch);
    axi_write(4'hC, 32'h11223344, 4'hF, 5, pulses);
    void'(model_write(4'hC, 32'h11223344, 4'hF));
    axi_read(4'hC, 0, rd);
    check("stall_write_result", rd, 32'h11223344);

    // reset with an AW held and a read response pending
    s_axi_awaddr = 4'h0; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_araddr = 4'hC; s_axi_arvalid = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    check("midrst_rvalid", {31'h0, s_axi_rvalid}, 32'h0);
    check("midrst_arready", {31'h0, s_axi_arready}, 32'h0);
    check("midrst_sw_out", {28'h0, sw_out}, 32'h1);
    tick();
    rst_n = 1'b1;
    m_speed = 4'h1; m_scratch = 32'h0; m_wraps = 32'h0;
    tick();
    check("midrst_rel_awready", {31'h0, s_axi_awready}, 32'h1);
    s_axi_wdata = 32'h1F; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    repeat (3) begin
      check("midrst_no_bvalid", {31'h0, s_axi_bvalid}, 32'h0);
      check("midrst_no_rvalid", {31'h0, s_axi_rvalid}, 32'h0);
      check("midrst_no_clear", {31'h0, cnt_clear}, 32'h0);
      tick();
    end
    s_axi_awaddr = 4'hC; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    check("midrst_late_bvalid", {31'h0, s_axi_bvalid}, 32'h1);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    void'(model_write(4'hC, 32'h1F, 4'hF));
    axi_read(4'hC, 0, rd);
    check("midrst_scratch", rd, 32'h1F);
    axi_read(4'h0, 0, rd);
    check("midrst_ctrl", rd, 32'h1);

    // randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 4);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      case (op)
        0, 1, 2: begin
          a = 4'($urandom_range(0, 3));
          a[3:2] = (op == 0) ? 2'd0 : ((op == 1) ? 2'd3 : 2'($urandom_range(1, 2)));
          axi_write(a, d, s, $urandom_range(0, 2), pulses);
          exp_clr = model_write(a, d, s);
          check("rand_clear", pulses, exp_clr);
        end
        3: begin
          a = 4'($urandom_range(0, 15));
          axi_read(a, $urandom_range(0, 2), rd);
          check("rand_read", rd, model_read(a));
        end
        default: begin
          case ($urandom_range(0, 2))
            0:       v = 32'hFFFFFFFF;
            1:       v = 32'h0;
            default: v = $urandom;
          endcase
          step(v);
        end
      endcase
      check("rand_sw_out", {28'h0, sw_out}, {28'h0, m_speed});
    end
    axi_read(4'h8, 0, rd);
    check("final_wraps", rd, m_wraps);
    axi_read(4'hC, 0, rd);
    check("final_scratch", rd, m_scratch);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
